// File: rtl/s832_pkg.sv
// rtl/s832_pkg.sv - shared types, constants and MISR step for the s832 response compactor
package s832_pkg;

    localparam int RESP_W = 19;
    localparam int MISR_W = 24;

    localparam logic [MISR_W-1:0] POLY_DEF = 24'hC20001;
    localparam logic [MISR_W-1:0] SEED_DEF = 24'h000001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Galois shift with MSB feedback, then the response word is xor-ed into the low bits.
    function automatic logic [MISR_W-1:0] misr_step(
        input logic [MISR_W-1:0] sig,
        input logic [RESP_W-1:0] resp,
        input logic [MISR_W-1:0] poly
    );
        logic [MISR_W-1:0] nxt;
        nxt = {sig[MISR_W-2:0], 1'b0} ^ (sig[MISR_W-1] ? poly : '0);
        return nxt ^ MISR_W'(resp);
    endfunction

endpackage

// File: rtl/s832_resp_misr_if.sv
// rtl/s832_resp_misr_if.sv - window control, response sample and signature handshake bundle
interface s832_resp_misr_if #(
    parameter int SIG_W = s832_pkg::MISR_W
) ();
    import s832_pkg::*;

    logic              start;
    logic [15:0]       win_len;
    logic              abort;
    logic              resp_valid;
    logic [RESP_W-1:0] resp;
    logic              busy;
    logic              sig_valid;
    logic              sig_ack;
    logic [SIG_W-1:0]  sig;
    logic [15:0]       count;

    modport master (
        output start, win_len, abort, resp_valid, resp, sig_ack,
        input  busy, sig_valid, sig, count
    );

    modport slave (
        input  start, win_len, abort, resp_valid, resp, sig_ack,
        output busy, sig_valid, sig, count
    );

endinterface

// File: rtl/misr_reg.sv
// rtl/misr_reg.sv - signature register with load-seed / fold / hold control
module misr_reg
    import s832_pkg::*;
#(
    parameter int               SIG_W = MISR_W,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(POLY_DEF),
    parameter logic [SIG_W-1:0] SEED  = SIG_W'(SEED_DEF)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              fold_i,
    input  logic [RESP_W-1:0] resp_i,
    output logic [SIG_W-1:0]  sig_o
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;
    logic [SIG_W-1:0] fold_val;

    // The shared step function is fixed at the package width; other widths use the same rule inline.
    generate
        if (SIG_W == MISR_W) begin : g_pkg_step
            assign fold_val = misr_step(sig_q, resp_i, POLY);
        end else begin : g_wide_step
            assign fold_val = {sig_q[SIG_W-2:0], 1'b0}
                            ^ (sig_q[SIG_W-1] ? POLY : '0)
                            ^ SIG_W'(resp_i);
        end
    endgenerate

    always_comb begin
        sig_d = sig_q;
        if (load_i) begin
            sig_d = SEED;
        end else if (fold_i) begin
            sig_d = fold_val;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/s832_resp_misr.sv
// rtl/s832_resp_misr.sv - windowed MISR compactor for the 19 s832 primary outputs
module s832_resp_misr
    import s832_pkg::*;
#(
    parameter int               SIG_W = MISR_W,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(POLY_DEF),
    parameter logic [SIG_W-1:0] SEED  = SIG_W'(SEED_DEF)
) (
    input  logic             CK,
    input  logic             RN,
    s832_resp_misr_if.slave  bus
);

    state_e      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [15:0] len_q, len_d;
    logic [15:0] count_inc;
    logic        load_seed;
    logic        fold;

    assign count_inc = count_q + 16'd1;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        len_d     = len_q;
        load_seed = 1'b0;
        fold      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    load_seed = 1'b1;
                    count_d   = '0;
                    if (bus.win_len != 16'd0) begin
                        len_d   = bus.win_len;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                // abort beats a fold arriving on the same cycle
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (bus.resp_valid) begin
                    fold    = 1'b1;
                    count_d = count_inc;
                    if (count_inc == len_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (bus.abort || bus.sig_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            len_q   <= len_d;
        end
    end

    misr_reg #(
        .SIG_W (SIG_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr_reg (
        .clk_i  (CK),
        .rst_ni (RN),
        .load_i (load_seed),
        .fold_i (fold),
        .resp_i (bus.resp),
        .sig_o  (bus.sig)
    );

    assign bus.busy      = (state_q == ST_RUN);
    assign bus.sig_valid = (state_q == ST_DONE);
    assign bus.count     = count_q;

endmodule

// File: tb/tb_s832_resp_misr.sv
// tb/tb_s832_resp_misr.sv - randomized self-checking bench against a GF(2) polynomial model
module tb_s832_resp_misr;
    import s832_pkg::*;

    logic CK = 1'b0;
    logic RN;
    always #5 CK = ~CK;

    s832_resp_misr_if #(.SIG_W(24)) bus ();
    s832_resp_misr_if #(.SIG_W(24)) fbus ();

    s832_resp_misr dut (
        .CK  (CK),
        .RN  (RN),
        .bus (bus)
    );

    s832_resp_misr #(.SEED(24'h800000)) dut_fb (
        .CK  (CK),
        .RN  (RN),
        .bus (fbus)
    );

    int total = 0;
    int bad   = 0;

    // Full characteristic polynomial x^24+x^23+x^22+x^17+1 including the x^24 term.
    localparam logic [24:0] FULL_POLY = 25'h1C20001;

    logic [23:0] m_sig;
    int          m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Signature times x, reduced modulo the polynomial, plus the response as a polynomial.
    function automatic logic [23:0] ref_fold(input logic [23:0] s, input logic [18:0] r);
        logic [24:0] p;
        p = {1'b0, s} << 1;
        if (p[24]) p = p ^ FULL_POLY;
        return p[23:0] ^ {5'd0, r};
    endfunction

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start = 0;  bus.win_len = 0;  bus.abort = 0;
        bus.resp_valid = 0;  bus.resp = 0;  bus.sig_ack = 0;
        fbus.start = 0; fbus.win_len = 0; fbus.abort = 0;
        fbus.resp_valid = 0; fbus.resp = 0; fbus.sig_ack = 0;
    endtask

    task automatic start_window(input logic [15:0] len);
        bus.start = 1;
        bus.win_len = len;
        tick();
        bus.start = 0;
        bus.win_len = 16'($urandom);
        m_sig = 24'h000001;
        m_cnt = 0;
    endtask

    task automatic fold_cycle(input logic v, input logic [18:0] r);
        bus.resp_valid = v;
        bus.resp = r;
        tick();
        bus.resp_valid = 0;
        if (v) begin
            m_sig = ref_fold(m_sig, r);
            m_cnt++;
        end
    endtask

    task automatic ack_done();
        bus.sig_ack = 1;
        tick();
        bus.sig_ack = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [18:0] gap_resp [3];
        logic [23:0] held;
        int len, budget;

        idle_inputs();
        RN = 0;
        tick(); tick();
        check("rst_sig", bus.sig, 0);
        check("rst_count", bus.count, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_valid", bus.sig_valid, 0);
        RN = 1;
        tick();

        // single sample window
        start_window(16'd1);
        check("one_busy", bus.busy, 1);
        check("one_seed", bus.sig, 24'h000001);
        fold_cycle(1, 19'h00001);
        check("one_valid", bus.sig_valid, 1);
        check("one_sig", bus.sig, 24'h000003);
        check("one_count", bus.count, 1);
        ack_done();
        check("one_idle", bus.sig_valid, 0);
        check("one_hold", bus.sig, 24'h000003);

        // zero-length window goes straight to DONE
        start_window(16'd0);
        check("zero_valid", bus.sig_valid, 1);
        check("zero_busy", bus.busy, 0);
        check("zero_sig", bus.sig, 24'h000001);
        check("zero_count", bus.count, 0);
        ack_done();

        // gapped valid, 1,0,1,0,1
        gap_resp[0] = 19'h7FFFF; gap_resp[1] = 19'h40000; gap_resp[2] = 19'h00005;
        start_window(16'd3);
        for (int i = 0; i < 5; i++) begin
            check("gap_not_done", bus.sig_valid, 0);
            if (i % 2 == 0) fold_cycle(1, gap_resp[i/2]);
            else fold_cycle(0, 19'($urandom));
        end
        check("gap_valid", bus.sig_valid, 1);
        check("gap_count", bus.count, 3);
        check("gap_sig", bus.sig, m_sig);

        // DONE holds through a long ack delay; start pulses are ignored
        held = m_sig;
        for (int i = 0; i < 10; i++) begin
            bus.start = (i == 3);
            bus.win_len = 16'd7;
            bus.resp_valid = 1;
            bus.resp = 19'($urandom);
            tick();
            check("hold_sig", bus.sig, held);
            check("hold_valid", bus.sig_valid, 1);
        end
        idle_inputs();
        check("hold_count", bus.count, 3);
        ack_done();
        check("ack_idle_valid", bus.sig_valid, 0);
        check("ack_idle_busy", bus.busy, 0);

        // abort on the 2nd RUN cycle of a 5-sample window
        start_window(16'd5);
        fold_cycle(1, 19'h12345);
        bus.abort = 1;
        fold_cycle(1, 19'h54321);
        m_sig = ref_fold(24'h000001, 19'h12345);
        bus.abort = 0;
        check("abort_busy", bus.busy, 0);
        check("abort_valid", bus.sig_valid, 0);
        check("abort_count", bus.count, 1);
        check("abort_sig", bus.sig, m_sig);
        for (int i = 0; i < 6; i++) begin
            bus.resp_valid = 1;
            tick();
            check("abort_no_valid", bus.sig_valid, 0);
        end
        bus.resp_valid = 0;

        // start together with abort in IDLE is dropped
        bus.start = 1; bus.abort = 1; bus.win_len = 16'd2;
        tick();
        idle_inputs();
        check("sa_busy", bus.busy, 0);
        check("sa_valid", bus.sig_valid, 0);
        check("sa_count", bus.count, 1);

        // feedback path with MSB-set seed
        fbus.start = 1; fbus.win_len = 16'd1;
        tick();
        fbus.start = 0;
        fbus.resp_valid = 1; fbus.resp = 19'h0;
        tick();
        fbus.resp_valid = 0;
        check("fb_valid", fbus.sig_valid, 1);
        check("fb_sig", fbus.sig, ref_fold(24'h800000, 19'h0));
        check("fb_sig_const", fbus.sig, 24'hC20001);
        fbus.sig_ack = 1;
        tick();
        fbus.sig_ack = 0;

        // asynchronous reset mid-RUN
        start_window(16'd4);
        fold_cycle(1, 19'h0ABCD);
        fold_cycle(1, 19'h13579);
        #2 RN = 0;
        #1;
        check("arst_sig", bus.sig, 0);
        check("arst_count", bus.count, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_valid", bus.sig_valid, 0);
        tick();
        RN = 1;
        tick();
        start_window(16'd2);
        fold_cycle(1, 19'h00F0F);
        fold_cycle(1, 19'h70001);
        check("post_rst_valid", bus.sig_valid, 1);
        check("post_rst_sig", bus.sig, m_sig);
        check("post_rst_count", bus.count, 2);
        ack_done();

        // randomized windows with gaps, late win_len changes and random ack delay
        for (int w = 0; w < 12; w++) begin
            len = (w == 5) ? 0 : int'($urandom_range(1, 14));
            start_window(16'(len));
            budget = 200;
            while (m_cnt < len && budget > 0) begin
                check("rnd_busy", bus.busy, 1);
                fold_cycle(($urandom_range(0, 3) != 0), 19'($urandom));
                bus.win_len = 16'($urandom);
                budget--;
            end
            if (budget == 0) check("rnd_timeout", 0, 1);
            check("rnd_valid", bus.sig_valid, 1);
            check("rnd_sig", bus.sig, m_sig);
            check("rnd_count", bus.count, 32'(len));
            for (int d = int'($urandom_range(0, 3)); d > 0; d--) begin
                bus.resp_valid = 1;
                bus.resp = 19'($urandom);
                tick();
                check("rnd_hold", bus.sig, m_sig);
            end
            bus.resp_valid = 0;
            ack_done();
            check("rnd_idle", bus.sig_valid, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
